// File: rtl/uart_tx_periph_pkg.sv
// uart_tx_periph_pkg: register map, status bits, store strobes and FSM states for the UART TX peripheral
package uart_tx_periph_pkg;

    localparam logic [3:0] UART_TXDATA  = 4'h0;
    localparam logic [3:0] UART_STATUS  = 4'h4;
    localparam logic [3:0] UART_DIVISOR = 4'h8;

    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_IDLE  = 2;
    localparam int ST_OVF   = 3;
    localparam int ST_PAR   = 4;
    localparam int ST_LEVEL = 8;

    localparam logic [2:0] WE_NONE = 3'b000;
    localparam logic [2:0] WE_SB   = 3'b100;
    localparam logic [2:0] WE_SH   = 3'b010;
    localparam logic [2:0] WE_SW   = 3'b001;

`ifdef UART_TX_PARITY_EN
    localparam logic PAR_EN = 1'b1;
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    localparam logic PAR_EN = 1'b0;
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    // Word-aligned register hit; the byte-lane bits of the offset are ignored.
    function automatic logic hit(input logic [3:0] a, input logic [3:0] off);
        return (a & 4'hC) == off;
    endfunction

endpackage

// File: rtl/uart_tx_periph_sync_fifo.sv
// uart_tx_periph_sync_fifo: synchronous FIFO with push/pop/full/empty/level, async active-low reset
module uart_tx_periph_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = level == (AW+1)'(DEPTH);
    assign empty   = level == '0;
    assign dout    = mem[rptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage array; contents need no reset since the pointers define validity.
    always_ff @(posedge clk)
        if (do_push) mem[wptr] <= din;

    // Pointers wrap naturally at the power-of-two depth; level tracks occupancy.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop) rptr <= rptr + 1'b1;
            level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end

endmodule

// File: rtl/uart_tx_periph.sv
// uart_tx_periph: memory-mapped 8N1 UART transmitter with TX FIFO; `UART_TX_PARITY_EN adds an even-parity bit
module uart_tx_periph #(
    parameter int CLK_HZ     = 12_000_000,
    parameter int BAUD       = 115_200,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sel,
    input  logic [3:0]  addr,
    input  logic [2:0]  write_enable,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        uart_txd,
    output logic        irq_empty
);
    import uart_tx_periph_pkg::*;

    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(CLK_HZ / BAUD - 1);

    state_t           state;
    state_t           next;
    logic [DIV_W-1:0] divisor;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             overflow;
    logic             fifo_full;
    logic             fifo_empty;
    logic [LW-1:0]    fifo_level;
    logic [7:0]       fifo_dout;
    logic             wr;
    logic             rd;
    logic             push;
    logic             load;
    logic             bit_end;
    logic             txd_d;
    logic [31:0]      status;
    logic [31:0]      rdata;
    logic             unused_ok;
`ifdef UART_TX_PARITY_EN
    logic             par;
`endif

    assign wr        = sel && write_enable != WE_NONE;
    assign rd        = sel && write_enable == WE_NONE;
    assign push      = wr && hit(addr, UART_TXDATA);
    assign bit_end   = cnt == '0;
    assign unused_ok = ^data_in[31:DIV_W];

    assign status = 32'(fifo_level) << ST_LEVEL | 32'(PAR_EN) << ST_PAR | 32'(overflow) << ST_OVF
                  | 32'(state == S_IDLE) << ST_IDLE | 32'(fifo_empty) << ST_EMPTY | 32'(fifo_full) << ST_FULL;
    assign rdata  = hit(addr, UART_STATUS)  ? status :
                    hit(addr, UART_DIVISOR) ? 32'(divisor) : 32'b0;

    uart_tx_periph_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (load),
        .din   (data_in[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Register file: divisor (word stores only), sticky overflow, registered read port.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            divisor  <= DIV_RST;
            overflow <= 1'b0;
            data_out <= '0;
        end else begin
            if (wr && hit(addr, UART_DIVISOR) && write_enable == WE_SW) divisor <= data_in[DIV_W-1:0];
            if (push && fifo_full && !load) overflow <= 1'b1;
            else if (wr && hit(addr, UART_STATUS) && data_in[ST_OVF]) overflow <= 1'b0;
            if (rd) data_out <= rdata;
        end

    // State register plus datapath: frame load, per-bit down-counter, shifter, registered line outputs.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            div_q     <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            uart_txd  <= 1'b1;
            irq_empty <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par       <= 1'b0;
`endif
        end else begin
            state     <= next;
            uart_txd  <= txd_d;
            irq_empty <= fifo_empty && state == S_IDLE;
            if (load) begin
                shreg   <= fifo_dout;
                div_q   <= divisor;
                cnt     <= divisor;
                bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                par     <= ^fifo_dout;
`endif
            end else if (state != S_IDLE) begin
                if (bit_end) begin
                    cnt <= div_q;
                    if (state == S_DATA) begin
                        shreg   <= shreg >> 1;
                        bit_idx <= bit_idx + 3'd1;
                    end
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end

    // Next-state logic; STOP with a queued byte chains straight into START.
    always_comb begin
        next = state;
        case (state)
            S_IDLE:   next = fifo_empty ? S_IDLE : S_START;
            S_START:  next = bit_end ? S_DATA : S_START;
`ifdef UART_TX_PARITY_EN
            S_DATA:   next = (bit_end && bit_idx == 3'd7) ? S_PARITY : S_DATA;
            S_PARITY: next = bit_end ? S_STOP : S_PARITY;
`else
            S_DATA:   next = (bit_end && bit_idx == 3'd7) ? S_STOP : S_DATA;
`endif
            S_STOP:   next = !bit_end ? S_STOP : fifo_empty ? S_IDLE : S_START;
            default:  next = S_IDLE;
        endcase
    end

    // Outputs: frame load/pop strobe and the serial bit for the current state.
    always_comb begin
        load  = !fifo_empty && (state == S_IDLE || (state == S_STOP && bit_end));
        txd_d = 1'b1;
        if (state == S_START) txd_d = 1'b0;
        if (state == S_DATA) txd_d = shreg[0];
`ifdef UART_TX_PARITY_EN
        if (state == S_PARITY) txd_d = par;
`endif
    end

endmodule

// File: tb/tb_uart_tx_periph.sv
// tb_uart_tx_periph: directed self-checking bench for uart_tx_periph (honours UART_TX_PARITY_EN)
module tb_uart_tx_periph;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic [3:0]  addr;
    logic [2:0]  write_enable;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        uart_txd;
    logic        irq_empty;

    int errors = 0;
    int checks = 0;

    localparam logic [2:0] SB = 3'b100;
    localparam logic [2:0] SH = 3'b010;
    localparam logic [2:0] SW = 3'b001;
    localparam logic [31:0] DIV_RST = 32'd103;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
    localparam logic [31:0] PB = 32'h10;
`else
    localparam int FB = 10;
    localparam logic [31:0] PB = 32'h0;
`endif

    uart_tx_periph dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sel          (sel),
        .addr         (addr),
        .write_enable (write_enable),
        .data_in      (data_in),
        .data_out     (data_out),
        .uart_txd     (uart_txd),
        .irq_empty    (irq_empty)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Expected line waveform of one frame, one entry per clock, sample 0 = first start-bit clock.
    function automatic logic [255:0] wave(input logic [7:0] b, input int cpb);
        logic [10:0]  bits;
        logic [255:0] w;
        bits = (FB == 11) ? {1'b1, ^b, b, 1'b0} : {2'b11, b, 1'b0};
        w = '0;
        for (int j = 0; j < FB; j++)
            for (int c = 0; c < cpb; c++)
                w[j*cpb+c] = bits[j];
        return w;
    endfunction

    task automatic bus_wr(input logic [3:0] a, input logic [2:0] we, input logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; addr = a; write_enable = we; data_in = d;
        @(negedge clk);
        sel = 1'b0; write_enable = 3'b000; data_in = '0;
    endtask

    task automatic bus_rd(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; addr = a; write_enable = 3'b000;
        @(negedge clk);
        d = data_out;
        sel = 1'b0;
    endtask

    task automatic wait_start(input int limit, output logic ok);
        for (int i = 0; i < limit && uart_txd; i++) @(negedge clk);
        ok = !uart_txd;
    endtask

    task automatic wait_high(input int limit, output logic ok);
        for (int i = 0; i < limit && !uart_txd; i++) @(negedge clk);
        ok = uart_txd;
    endtask

    task automatic capture(input int n, output logic [255:0] got);
        got = '0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            got[i] = uart_txd;
        end
    endtask

    task automatic test_reset;
        logic [31:0] d;
        checks++; if (uart_txd !== 1'b1) begin errors++; $display("FAIL reset_txd got=%b exp=1", uart_txd); end
        checks++; if (irq_empty !== 1'b1) begin errors++; $display("FAIL reset_irq got=%b exp=1", irq_empty); end
        checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL reset_data_out got=%h exp=0", data_out); end
        bus_rd(4'h4, d);
        checks++; if (d !== (32'h6 | PB)) begin errors++; $display("FAIL reset_status got=%h exp=%h", d, 32'h6 | PB); end
        bus_rd(4'h8, d);
        checks++; if (d !== DIV_RST) begin errors++; $display("FAIL reset_divisor got=%h exp=%h", d, DIV_RST); end
        addr = 4'h4;
        repeat (3) @(negedge clk);
        checks++; if (data_out !== DIV_RST) begin errors++; $display("FAIL read_hold got=%h exp=%h", data_out, DIV_RST); end
        bus_wr(4'hC, SW, 32'hFFFF_FFFF);
        bus_rd(4'hC, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmapped_read got=%h exp=0", d); end
        bus_rd(4'h0, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL txdata_read got=%h exp=0", d); end
        bus_rd(4'h9, d);
        checks++; if (d !== DIV_RST) begin errors++; $display("FAIL divisor_lane_ignored got=%h exp=%h", d, DIV_RST); end
    endtask

    task automatic test_frame;
        logic [255:0] got;
        logic [255:0] exp;
        bus_wr(4'h8, SW, 32'd3);
        bus_wr(4'h0, SW, 32'h55);
        checks++; if (uart_txd !== 1'b1) begin errors++; $display("FAIL latency_k0 got=%b exp=1", uart_txd); end
        @(negedge clk);
        checks++; if (uart_txd !== 1'b1) begin errors++; $display("FAIL latency_k1 got=%b exp=1", uart_txd); end
        @(negedge clk);
        checks++; if (uart_txd !== 1'b0) begin errors++; $display("FAIL latency_k2 got=%b exp=0", uart_txd); end
        capture(FB*4, got);
        exp = wave(8'h55, 4);
        checks++; if (got !== exp) begin errors++; $display("FAIL frame_55 got=%h exp=%h", got, exp); end
        checks++; if (irq_empty !== 1'b0) begin errors++; $display("FAIL irq_during_stop got=%b exp=0", irq_empty); end
        @(negedge clk);
        checks++; if (irq_empty !== 1'b1) begin errors++; $display("FAIL irq_after_stop got=%b exp=1", irq_empty); end
    endtask

    task automatic test_back_to_back;
        logic [255:0] got;
        logic [255:0] exp;
        logic ok;
        bus_wr(4'h0, SB, 32'h41);
        bus_wr(4'h0, SH, 32'h42);
        wait_start(10, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL b2b_start got=%b exp=1", ok); end
        capture(2*FB*4, got);
        exp = wave(8'h41, 4) | (wave(8'h42, 4) << (FB*4));
        checks++; if (got !== exp) begin errors++; $display("FAIL b2b_frames got=%h exp=%h", got, exp); end
        repeat (2) @(negedge clk);
        checks++; if (irq_empty !== 1'b1) begin errors++; $display("FAIL b2b_irq got=%b exp=1", irq_empty); end
    endtask

    task automatic test_parity;
        logic [255:0] got;
        logic ok;
        bus_wr(4'h0, SW, 32'h07);
        wait_start(10, ok);
        capture(FB*4, got);
        checks++; if (ok !== 1'b1 || got !== wave(8'h07, 4)) begin errors++; $display("FAIL frame_07 got=%h exp=%h", got, wave(8'h07, 4)); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_overflow;
        logic [255:0] got;
        logic [255:0] exp;
        logic [31:0] d;
        logic ok;
        int lows;
        bus_wr(4'h8, SW, 32'd200);
        bus_wr(4'h0, SW, 32'hFF);
        for (int i = 0; i < 17; i++)
            bus_wr(4'h0, (i % 3 == 0) ? SB : (i % 3 == 1) ? SH : SW, 32'(8'h30 + i));
        bus_rd(4'h4, d);
        checks++; if (d !== (32'h1009 | PB)) begin errors++; $display("FAIL ovf_status got=%h exp=%h", d, 32'h1009 | PB); end
        checks++; if (irq_empty !== 1'b0) begin errors++; $display("FAIL ovf_irq got=%b exp=0", irq_empty); end
        bus_wr(4'h4, SW, 32'h8);
        bus_rd(4'h4, d);
        checks++; if (d !== (32'h1001 | PB)) begin errors++; $display("FAIL ovf_clear got=%h exp=%h", d, 32'h1001 | PB); end
        bus_wr(4'h8, SW, 32'd0);
        wait_high(1000, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL ovf_wait_high got=%b exp=1", ok); end
        wait_start(3000, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL ovf_wait_start got=%b exp=1", ok); end
        capture(16*FB, got);
        exp = '0;
        for (int i = 0; i < 16; i++) exp = exp | (wave(8'(8'h30 + i), 1) << (i*FB));
        checks++; if (got !== exp) begin errors++; $display("FAIL ovf_frames got=%h exp=%h", got, exp); end
        lows = 0;
        repeat (20) begin @(negedge clk); if (!uart_txd) lows++; end
        checks++; if (lows !== 0) begin errors++; $display("FAIL ovf_dropped_byte_sent lows=%0d exp=0", lows); end
        checks++; if (irq_empty !== 1'b1) begin errors++; $display("FAIL ovf_irq_end got=%b exp=1", irq_empty); end
        bus_rd(4'h4, d);
        checks++; if (d !== (32'h6 | PB)) begin errors++; $display("FAIL ovf_status_end got=%h exp=%h", d, 32'h6 | PB); end
    endtask

    task automatic test_divisor_change;
        logic [255:0] got;
        logic [255:0] exp;
        logic [31:0] d;
        logic ok;
        bus_wr(4'h8, SW, 32'd3);
        bus_wr(4'h0, SW, 32'h3C);
        fork
            begin
                wait_start(10, ok);
                capture(12*FB, got);
            end
            begin
                repeat (8) @(negedge clk);
                bus_wr(4'h8, SW, 32'd7);
                bus_wr(4'h8, SB, 32'hFF);
                bus_wr(4'h8, SH, 32'hFF);
                bus_wr(4'h0, SW, 32'hC3);
            end
        join
        exp = wave(8'h3C, 4) | (wave(8'hC3, 8) << (FB*4));
        checks++; if (ok !== 1'b1 || got !== exp) begin errors++; $display("FAIL div_change got=%h exp=%h", got, exp); end
        bus_rd(4'h8, d);
        checks++; if (d !== 32'd7) begin errors++; $display("FAIL div_readback got=%h exp=7", d); end
    endtask

    task automatic test_reset_midframe;
        logic [31:0] d;
        logic ok;
        int lows;
        bus_wr(4'h8, SW, 32'd3);
        bus_wr(4'h0, SW, 32'h00);
        bus_wr(4'h0, SW, 32'h11);
        wait_start(10, ok);
        repeat (8) @(negedge clk);
        checks++; if (ok !== 1'b1 || uart_txd !== 1'b0) begin errors++; $display("FAIL mid_data_low got=%b exp=0", uart_txd); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (uart_txd !== 1'b1) begin errors++; $display("FAIL async_reset_txd got=%b exp=1", uart_txd); end
        checks++; if (data_out !== 32'h0 || irq_empty !== 1'b1) begin errors++; $display("FAIL async_reset_regs data_out=%h irq=%b exp 0/1", data_out, irq_empty); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        lows = 0;
        repeat (60) begin @(negedge clk); if (!uart_txd) lows++; end
        checks++; if (lows !== 0) begin errors++; $display("FAIL residual_frame lows=%0d exp=0", lows); end
        bus_rd(4'h4, d);
        checks++; if (d !== (32'h6 | PB)) begin errors++; $display("FAIL post_reset_status got=%h exp=%h", d, 32'h6 | PB); end
        bus_rd(4'h8, d);
        checks++; if (d !== DIV_RST) begin errors++; $display("FAIL post_reset_divisor got=%h exp=%h", d, DIV_RST); end
    endtask

    initial begin
        rst_n = 1'b0; sel = 1'b0; addr = '0; write_enable = '0; data_in = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        test_reset;
        test_frame;
        test_back_to_back;
        test_parity;
        test_overflow;
        test_divisor_change;
        test_reset_midframe;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
